// File: rtl/wb_rr_arbiter.sv
// N-master to 1-slave Wishbone classic arbiter: round-robin grant, cycle-locked ownership, optional burst cap.
// Define WB_ARB_TIMEOUT_EN to add a slave-hang watchdog that terminates the cycle with an error ack.
module wb_rr_arbiter #(
  parameter int unsigned N_MST          = 3,
  parameter int unsigned AW             = 32,
  parameter int unsigned DW             = 32,
  parameter int unsigned MAX_BURST      = 0,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_MST-1:0]         m_cyc_i,
  input  logic [N_MST-1:0]         m_stb_i,
  input  logic [N_MST-1:0]         m_we_i,
  input  logic [N_MST*(DW/8)-1:0]  m_sel_i,
  input  logic [N_MST*AW-1:0]      m_adr_i,
  input  logic [N_MST*DW-1:0]      m_dat_i,
  output logic [N_MST-1:0]         m_ack_o,
  output logic [DW-1:0]            m_dat_o,
  output logic                     s_cyc_o,
  output logic                     s_stb_o,
  output logic                     s_we_o,
  output logic [DW/8-1:0]          s_sel_o,
  output logic [AW-1:0]            s_adr_o,
  output logic [DW-1:0]            s_dat_o,
  input  logic                     s_ack_i,
  input  logic [DW-1:0]            s_dat_i,
  output logic [N_MST-1:0]         gnt_o,
  output logic                     err_o
);

  localparam int unsigned SW = DW / 8;
  localparam int unsigned IW = (N_MST > 1) ? $clog2(N_MST) : 1;
  localparam int unsigned BW = (MAX_BURST > 1) ? $clog2(MAX_BURST + 1) : 1;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;

  logic [0:0]       state, state_nxt;
  logic [N_MST-1:0] gnt_nxt;
  logic [IW-1:0]    last, last_nxt, pick, cand;
  logic [BW-1:0]    burst, burst_nxt;
  logic [N_MST-1:0] req;
  logic             busy, others, cap_hit, tmo, rel, found;

  assign req    = m_cyc_i & m_stb_i;
  assign busy   = (state == BUSY);
  assign others = |(req & ~gnt_o);

  // While granted, 'last' is the owner index; the slave side is a plain mux of that master.
  assign s_cyc_o = busy & m_cyc_i[last];
  assign s_stb_o = busy & m_stb_i[last];
  assign s_we_o  = busy & m_we_i[last];
  assign s_sel_o = busy ? m_sel_i[32'(last)*SW +: SW] : '0;
  assign s_adr_o = busy ? m_adr_i[32'(last)*AW +: AW] : '0;
  assign s_dat_o = busy ? m_dat_i[32'(last)*DW +: DW] : '0;
  assign m_ack_o = busy ? (gnt_o & {N_MST{s_ack_i | tmo}}) : '0;

  assign cap_hit = (MAX_BURST != 0) && s_ack_i && others &&
                   ((32'(burst) + 32'd1) >= MAX_BURST);

`ifdef WB_ARB_TIMEOUT_EN
  localparam int unsigned TW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  logic [TW-1:0] tcnt;

  // Counts strobe cycles without ack; idle between grants clears it for the next owner.
  always_ff @(posedge clk) begin
    if (rst || !busy || s_ack_i) begin
      tcnt <= '0;
    end else if (s_stb_o && (tcnt != TW'(TIMEOUT_CYCLES))) begin
      tcnt <= tcnt + TW'(1);
    end
  end

  assign tmo     = busy && s_stb_o && !s_ack_i && (tcnt == TW'(TIMEOUT_CYCLES));
  assign err_o   = tmo;
  assign m_dat_o = tmo ? DW'(32'hDEAD_BEEF) : s_dat_i;
`else
  logic unused_timeout;
  assign unused_timeout = ^(32'(TIMEOUT_CYCLES));
  assign tmo     = 1'b0;
  assign err_o   = 1'b0;
  assign m_dat_o = s_dat_i;
`endif

  assign rel = !m_cyc_i[last] || cap_hit || tmo;

  // Round-robin search starting one past the previous owner.
  always_comb begin
    pick  = last;
    found = 1'b0;
    cand  = '0;
    for (int unsigned i = 1; i <= N_MST; i++) begin
      cand = IW'((32'(last) + i) % N_MST);
      if (!found && req[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    gnt_nxt   = gnt_o;
    last_nxt  = last;
    burst_nxt = burst;
    case (state)
      IDLE: begin
        if (|req) begin
          state_nxt = BUSY;
          gnt_nxt   = N_MST'(1) << pick;
          last_nxt  = pick;
          burst_nxt = '0;
        end
      end
      BUSY: begin
        if (s_ack_i && (burst != BW'(MAX_BURST))) begin
          burst_nxt = burst + BW'(1);
        end
        if (rel) begin
          state_nxt = IDLE;
          gnt_nxt   = '0;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      gnt_o <= '0;
      last  <= IW'(N_MST - 1);
      burst <= '0;
    end else begin
      state <= state_nxt;
      gnt_o <= gnt_nxt;
      last  <= last_nxt;
      burst <= burst_nxt;
    end
  end

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Bench for wb_rr_arbiter (3 masters, burst cap 2): directed scenarios plus random traffic
// compared every cycle against an owner/pointer reference model.
module tb_wb_rr_arbiter;

  localparam int unsigned N  = 3;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned SW = 4;
  localparam int unsigned MB = 2;
  localparam int unsigned TO = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [N-1:0]    cyc, stb, we;
  logic [N*SW-1:0] sel;
  logic [N*AW-1:0] adr;
  logic [N*DW-1:0] wdat;
  logic            s_ack;
  logic [DW-1:0]   s_rdat;

  logic [N-1:0]    m_ack, gnt;
  logic [DW-1:0]   m_rdat, s_wdat;
  logic            s_cyc, s_stb, s_we, err;
  logic [SW-1:0]   s_sel;
  logic [AW-1:0]   s_adr;

  wb_rr_arbiter #(.N_MST(N), .AW(AW), .DW(DW), .MAX_BURST(MB), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst),
    .m_cyc_i(cyc), .m_stb_i(stb), .m_we_i(we), .m_sel_i(sel), .m_adr_i(adr), .m_dat_i(wdat),
    .m_ack_o(m_ack), .m_dat_o(m_rdat),
    .s_cyc_o(s_cyc), .s_stb_o(s_stb), .s_we_o(s_we), .s_sel_o(s_sel), .s_adr_o(s_adr),
    .s_dat_o(s_wdat), .s_ack_i(s_ack), .s_dat_i(s_rdat),
    .gnt_o(gnt), .err_o(err)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
  endtask

  // Reference model: who owns the slave, who owned it last, acks this tenure, stall cycles.
  int owner = -1;
  int ptr   = N - 1;
  int acks  = 0;
  int tw    = 0;
  bit model_ok = 1'b0;

  always @(negedge clk) begin
    logic [N-1:0]  e_gnt, e_ack;
    logic [6:0]    e_ctl;
    logic [AW-1:0] e_adr;
    logic [DW-1:0] e_dat, e_rdat;
    bit            e_tmo, rel, oth;
    int            k;
    if (rst) begin
      owner = -1; ptr = N - 1; acks = 0; tw = 0; model_ok = 1'b1;
    end else if (model_ok) begin
      e_gnt = '0; e_ctl = '0; e_adr = '0; e_dat = '0; e_tmo = 1'b0;
      if (owner >= 0) begin
        e_gnt = 3'(1) << owner;
        e_ctl = {cyc[owner], stb[owner], we[owner], sel[owner*SW +: SW]};
        e_adr = adr[owner*AW +: AW];
        e_dat = wdat[owner*DW +: DW];
`ifdef WB_ARB_TIMEOUT_EN
        e_tmo = stb[owner] && !s_ack && (tw == TO);
`endif
      end
      e_ack  = (owner >= 0 && (s_ack || e_tmo)) ? e_gnt : '0;
      e_rdat = e_tmo ? 32'hDEAD_BEEF : s_rdat;
      check("gnt", 64'(gnt), 64'(e_gnt));
      check("m_ack", 64'(m_ack), 64'(e_ack));
      check("s_ctl", 64'({s_cyc, s_stb, s_we, s_sel}), 64'(e_ctl));
      check("s_adr", 64'(s_adr), 64'(e_adr));
      check("s_dat", 64'(s_wdat), 64'(e_dat));
      check("m_dat", 64'(m_rdat), 64'(e_rdat));
      check("err", 64'(err), 64'(e_tmo));
      if (owner < 0) begin
        tw = 0;
        for (int i = 1; i <= N; i++) begin
          k = (ptr + i) % N;
          if (owner < 0 && cyc[k] && stb[k]) begin
            owner = k; ptr = k; acks = 0;
          end
        end
      end else begin
        rel = !cyc[owner] || e_tmo;
        oth = 1'b0;
        for (int j = 0; j < N; j++) if (j != owner && cyc[j] && stb[j]) oth = 1'b1;
        if (s_ack) begin
          acks++;
          if (MB != 0 && acks >= MB && oth) rel = 1'b1;
        end
        if (s_ack) tw = 0;
        else if (stb[owner]) tw++;
        if (rel) begin
          owner = -1; tw = 0;
        end
      end
    end
  end

  logic [N-1:0] ackd;

  task automatic set_m(input int k, input logic c, input logic s, input logic w,
                       input logic [SW-1:0] se, input logic [AW-1:0] a, input logic [DW-1:0] d);
    cyc[k] = c; stb[k] = s; we[k] = w;
    sel[k*SW +: SW] = se; adr[k*AW +: AW] = a; wdat[k*DW +: DW] = d;
  endtask

  task automatic begin_cycle();
    @(posedge clk); #1;
  endtask

  task automatic end_cycle();
    @(negedge clk);
    ackd = m_ack;
  endtask

  task automatic do_reset();
    begin_cycle(); rst = 1'b1;
    cyc = '0; stb = '0; we = '0; sel = '0; adr = '0; wdat = '0; s_ack = 1'b0; s_rdat = '0;
    end_cycle();
    begin_cycle(); end_cycle();
    begin_cycle(); rst = 1'b0; end_cycle();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int onsets[$];
    logic [N-1:0] prev;
    int idle_run, a1, a2, sw, r;
    logic [N-1:0] exp_rr [6];
    logic [N-1:0] exp_bu [10];
    exp_rr = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
    exp_bu = '{3'b010, 3'b010, 3'b000, 3'b100, 3'b100, 3'b000, 3'b010, 3'b010, 3'b010, 3'b000};
    cyc = '0; stb = '0; we = '0; sel = '0; adr = '0; wdat = '0; s_ack = 1'b0; s_rdat = '0;
    ackd = '0;

    // Reset state and a single read from master 0.
    do_reset();
    check("rst_gnt", 64'(gnt), 64'(0));
    check("rst_ack", 64'(m_ack), 64'(0));
    check("rst_s", 64'({s_cyc, s_stb, err}), 64'(0));
    begin_cycle(); set_m(0, 1, 1, 0, 4'hF, 32'h10, '0); end_cycle();
    check("rd_gnt_req", 64'(gnt), 64'(0));
    begin_cycle(); end_cycle();
    check("rd_gnt", 64'(gnt), 64'(3'b001));
    check("rd_adr", 64'(s_adr), 64'(32'h10));
    begin_cycle(); s_ack = 1'b1; s_rdat = 32'h1234_5678; end_cycle();
    check("rd_ack", 64'(m_ack), 64'(3'b001));
    check("rd_dat", 64'(m_rdat), 64'(32'h1234_5678));
    begin_cycle(); set_m(0, 0, 0, 0, '0, '0, '0); s_ack = 1'b0; end_cycle();
    begin_cycle(); end_cycle();
    check("rd_rel", 64'(gnt), 64'(0));

    // Three masters requesting continuously, single beats.
    do_reset();
    prev = '0; idle_run = 0;
    for (int c = 0; c < 40 && onsets.size() < 6; c++) begin
      begin_cycle();
      for (int k = 0; k < N; k++)
        if (ackd[k]) set_m(k, 0, 0, 0, '0, '0, '0);
        else set_m(k, 1, 1, 0, 4'hF, 32'(k) << 8, '0);
      #1; s_ack = s_stb; s_rdat = $urandom;
      end_cycle();
      if (gnt != '0 && prev == '0) begin
        if (onsets.size() > 0) check("rr_idle_gap", 64'(idle_run), 64'(1));
        onsets.push_back(int'(gnt));
      end
      idle_run = (gnt == '0) ? idle_run + 1 : 0;
      prev = gnt;
    end
    check("rr_count", 64'(onsets.size()), 64'(6));
    for (int i = 0; i < onsets.size() && i < 6; i++) check("rr_order", 64'(onsets[i]), 64'(exp_rr[i]));

    // Burst cap: master 1 wants 4 writes while master 2 waits.
    do_reset();
    a1 = 0; a2 = 0;
    for (int c = 0; c <= 10; c++) begin
      begin_cycle();
      set_m(1, a1 < 4, a1 < 4, 1, 4'hF, 32'h100 + 32'(a1) * 4, 32'hB0 + 32'(a1));
      set_m(2, a2 < 1, a2 < 1, 1, 4'hF, 32'h200, 32'hC0);
      #1; s_ack = s_stb;
      end_cycle();
      if (m_ack[1]) a1++;
      if (m_ack[2]) a2++;
      if (c >= 1) check("burst_gnt", 64'(gnt), 64'(exp_bu[c-1]));
    end
    check("burst_beats", 64'(a1), 64'(4));

    // Locked cycle: master 0 holds cyc with stb low.
    do_reset();
    begin_cycle(); set_m(0, 1, 1, 0, 4'hF, 32'h20, '0); #1; s_ack = s_stb; end_cycle();
    begin_cycle(); #1; s_ack = s_stb; end_cycle();
    check("lock_ack", 64'(m_ack), 64'(3'b001));
    for (int i = 0; i < 5; i++) begin
      begin_cycle(); set_m(0, 1, 0, 0, 4'hF, 32'h20, '0); set_m(1, 1, 1, 0, 4'hF, 32'h30, '0);
      #1; s_ack = s_stb; end_cycle();
      check("lock_gnt", 64'(gnt), 64'(3'b001));
      check("lock_cs", 64'({s_cyc, s_stb}), 64'(2'b10));
    end
    begin_cycle(); set_m(0, 0, 0, 0, '0, '0, '0); #1; s_ack = s_stb; end_cycle();
    begin_cycle(); s_ack = 1'b0; end_cycle();
    check("lock_idle", 64'(gnt), 64'(0));
    begin_cycle(); #1; s_ack = s_stb; end_cycle();
    check("lock_next", 64'(gnt), 64'(3'b010));
    begin_cycle(); set_m(1, 0, 0, 0, '0, '0, '0); s_ack = 1'b0; end_cycle();

    // Payload routing from master 2.
    do_reset();
    begin_cycle(); set_m(2, 1, 1, 1, 4'b0100, 32'h3800_0004, 32'hAABB_CCDD); end_cycle();
    begin_cycle(); end_cycle();
    check("wr_gnt", 64'(gnt), 64'(3'b100));
    check("wr_sel", 64'(s_sel), 64'(4'b0100));
    check("wr_adr", 64'(s_adr), 64'(32'h3800_0004));
    check("wr_dat", 64'(s_wdat), 64'(32'hAABB_CCDD));
    check("wr_we", 64'(s_we), 64'(1));
    begin_cycle(); s_ack = 1'b1; end_cycle();
    check("wr_ack", 64'(m_ack), 64'(3'b100));
    begin_cycle(); set_m(2, 0, 0, 0, '0, '0, '0); s_ack = 1'b0; end_cycle();

`ifdef WB_ARB_TIMEOUT_EN
    // Hung slave: watchdog terminates the cycle.
    do_reset();
    begin_cycle(); set_m(0, 1, 1, 0, 4'hF, 32'h40, '0); end_cycle();
    for (int i = 1; i <= 9; i++) begin
      begin_cycle(); end_cycle();
      if (i < 9) check("tmo_wait", 64'(m_ack), 64'(0));
    end
    check("tmo_ack", 64'(m_ack), 64'(3'b001));
    check("tmo_dat", 64'(m_rdat), 64'(32'hDEAD_BEEF));
    check("tmo_err", 64'(err), 64'(1));
    begin_cycle(); set_m(0, 0, 0, 0, '0, '0, '0); end_cycle();
    check("tmo_err_off", 64'(err), 64'(0));
    check("tmo_idle", 64'(gnt), 64'(0));
`endif

    // Random traffic with a mid-run reset.
    do_reset();
    sw = 0;
    for (int c = 0; c < 1500; c++) begin
      begin_cycle();
      if (c == 700) rst = 1'b1;
      if (c == 702) rst = 1'b0;
      for (int k = 0; k < N; k++) begin
        r = int'($urandom % 4);
        if (!cyc[k]) begin
          if (r == 0) set_m(k, 1, 1, 1'($urandom % 2), SW'($urandom), $urandom, $urandom);
        end else if (ackd[k]) begin
          if (r == 0) set_m(k, 0, 0, 0, '0, '0, '0);
          else if (r == 1) stb[k] = 1'b0;
          else set_m(k, 1, 1, 1'($urandom % 2), SW'($urandom), $urandom, $urandom);
        end else if (!stb[k]) begin
          if (r == 0) set_m(k, 0, 0, 0, '0, '0, '0);
          else if (r != 3) set_m(k, 1, 1, 1'($urandom % 2), SW'($urandom), $urandom, $urandom);
        end
      end
      #1;
      if (s_stb) begin
        if (sw >= 3 || ($urandom % 2) == 0) begin s_ack = 1'b1; sw = 0; end
        else begin s_ack = 1'b0; sw++; end
      end else begin
        sw = 0;
        s_ack = !s_cyc && (($urandom % 10) == 0);
      end
      s_rdat = $urandom;
      end_cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
